quad_decoder: RTL and testbench
===============================

# quad_decoder

Quadrature decoder and position counter for incremental-encoder inputs. It synchronizes and glitch-filters asynchronous A/B channels, then decodes Gray-code transitions into up/down steps. It keeps a loadable, wrapping position register and flags illegal double-bit transitions. It sits at the input side of the counting datapath and produces the direction and step information that a loadable up/down counter otherwise receives as control inputs.

## Interface
- WIDTH, 16, position register width (≥2)
- SYNC_STAGES, 2, synchronizer flops per channel (≥2)
- FILTER_LEN, 3, consecutive cycles a new A/B value must be stable before acceptance (≥1)

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- a_in  in  1  encoder channel A, asynchronous
- b_in  in  1  encoder channel B, asynchronous
- load  in  1  synchronous load of position
- load_value  in  WIDTH  value written to position on load
- err_clr  in  1  clears sticky err
- position  out  WIDTH  current count, unsigned, modulo 2^WIDTH
- dir  out  1  direction of the last counted step (1 = up)
- step  out  1  one-cycle pulse per counted step
- err  out  1  sticky illegal-transition flag

## Operation
- Reset values: position=0, dir=0, step=0, err=0. FSM state is INIT. Synchronizer flops, filter counter and filtered state are all 0.
- Input path: {a_in,b_in} passes through SYNC_STAGES flops as a 2-bit vector. A filter tracks the candidate value and its run length.
  - The run counter restarts at 1 when the synchronized value changes.
  - The counter increments while the synchronized value is unchanged, saturating at FILTER_LEN.
  - The candidate is accepted on the edge where the run reaches FILTER_LEN and the candidate differs from the filtered state.
- FSM:
  - INIT: the first accepted value (run reaches FILTER_LEN) is adopted as the filtered state. No step or err is produced. Next state is TRACK.
  - TRACK: each accepted value is decoded against the previous filtered state.
- Decode, state written as {A,B}:
  - Up sequence: 00→10→11→01→00. Each up transition gives position+1, dir=1, step=1.
  - Down sequence: reverse order. Each down transition gives position−1, dir=0, step=1.
  - Two-bit change (00↔11, 10↔01): err←1. The filtered state still updates. Position, dir and step are unchanged.
- Arithmetic: wrap at 2^WIDTH. All-ones +1 gives 0; 0 −1 gives all-ones. No saturation.
- load has priority over a step in the same cycle:
  - position←load_value.
  - The step is discarded: step=0 and dir is unchanged.
  - The filtered state still updates.
- load also acts in INIT.
- err_clr: err←0. If an illegal transition occurs in the same cycle, err stays 1 (set wins).
- rst asserted mid-operation returns the block to INIT immediately. All outputs return to their reset values asynchronously.

## Timing
- Latency:
  - Let E0 be the first clk edge sampling a new stable input level.
  - The synchronized value is valid after edge E0+SYNC_STAGES−1.
  - Acceptance, position update and step all occur at edge E0+SYNC_STAGES+FILTER_LEN−1. This is edge E0+4 with the defaults.
- Pulses shorter than FILTER_LEN cycles at the synchronizer output are rejected. Position and state do not change.
- A and B changing within the same filter window are accepted as one 2-bit change, which sets err.
- Maximum countable rate: one transition per SYNC_STAGES+FILTER_LEN cycles is guaranteed. Faster input is undefined but must never corrupt WIDTH arithmetic.
- step is high for exactly one cycle per counted transition. It is never high in INIT or on load cycles.
- load is synchronous, with a 1-cycle effect: position equals load_value after the edge sampling load=1.

## Structure
- Package quad_pkg holds:
  - enum fsm_t {INIT, TRACK}
  - enum xition_t {X_NONE, X_UP, X_DOWN, X_ILLEGAL}
  - the combinational decode function (prev, next) → xition_t
- Sub-module sync_filter, parameterized by W, SYNC_STAGES and FILTER_LEN. It is instantiated once with W=2 and outputs the accepted value plus an accept strobe.
- The top level contains the FSM, decode, position register, and the dir, step and err registers.

## Test plan
- Reset with a_in=b_in=1, then hold for 10 cycles → INIT adopts 11; position=0, step never pulses, err=0.
- From 00, apply four up transitions spaced 8 cycles apart → position 0→4, dir=1, four single-cycle step pulses, each at E0+4.
- load with load_value=16'h0001, then three down transitions → position 1→0→FFFF→FFFE, dir=0.
- 2-cycle glitch on a_in (defaults) → no acceptance, position unchanged, step=0. Then a 00→11 change → err=1, position unchanged. Then err_clr → err=0.
- load=1 with load_value=16'h1234 on the same edge an up transition is accepted → position=1234, step=0. The next up transition gives 1235.
- Assert rst mid-count at position=7 → position=0, err=0 immediately. The block re-enters INIT and the first accepted value causes no step.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and the Gray-code transition decoder for the quadrature decoder.
package quad_pkg;

  typedef enum logic [0:0] {INIT, TRACK} fsm_t;

  typedef enum logic [1:0] {X_NONE, X_UP, X_DOWN, X_ILLEGAL} xition_t;

  // Map {A,B} onto its position in the up sequence 00->10->11->01.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  function automatic xition_t decode(input logic [1:0] prev, input logic [1:0] next);
    logic [1:0] w_diff;
    w_diff = gray_idx(next) - gray_idx(prev);
    case (w_diff)
      2'd1:    return X_UP;
      2'd3:    return X_DOWN;
      2'd2:    return X_ILLEGAL;
      default: return X_NONE;
    endcase
  endfunction

endpackage

// File: rtl/quad_decoder_sync_filter.sv
// Multi-flop synchronizer plus run-length glitch filter; strobes o_accept when a new value
// has been stable for FILTER_LEN cycles.
module sync_filter #(
  parameter int unsigned W           = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  input  logic         i_first,
  output logic [W-1:0] o_prev,
  output logic [W-1:0] o_next,
  output logic         o_accept
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] LEN = CW'(FILTER_LEN);

  logic [SYNC_STAGES-1:0][W-1:0] r_sync;
  logic [W-1:0]                  r_cand;
  logic [W-1:0]                  r_filt;
  logic [CW-1:0]                 r_cnt;

  logic [W-1:0]  w_sync;
  logic          w_changed;
  logic [CW-1:0] w_cnt_d;
  logic          w_reach;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_changed = (w_sync != r_cand);
    w_cnt_d   = r_cnt;
    if (w_changed) begin
      w_cnt_d = CW'(1);
    end else if (r_cnt != LEN) begin
      w_cnt_d = r_cnt + CW'(1);
    end
    // Fire only on the edge the run first reaches LEN, not while it sits saturated.
    w_reach  = (w_cnt_d == LEN) && (w_changed || (r_cnt != LEN));
    o_accept = w_reach && (i_first || (w_sync != r_filt));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_cand <= '0;
      r_filt <= '0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_cand <= w_sync;
      r_cnt  <= w_cnt_d;
      if (o_accept) begin
        r_filt <= w_sync;
      end
    end
  end

  assign o_prev = r_filt;
  assign o_next = w_sync;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B Gray-code transitions drive a loadable wrapping position
// counter with direction, step pulse and sticky illegal-transition flag.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             err_clr,
  output logic [WIDTH-1:0] position,
  output logic             dir,
  output logic             step,
  output logic             err
);

  fsm_t             r_state;
  fsm_t             w_state_d;
  xition_t          w_xition;
  logic [1:0]       w_prev;
  logic [1:0]       w_next;
  logic             w_accept;
  logic             w_count;
  logic [WIDTH-1:0] r_position;
  logic             r_dir;
  logic             r_step;
  logic             r_err;

  sync_filter #(
    .W          (2),
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_sync_filter (
    .clk     (clk),
    .rst     (rst),
    .i_d     ({a_in, b_in}),
    .i_first (r_state == INIT),
    .o_prev  (w_prev),
    .o_next  (w_next),
    .o_accept(w_accept)
  );

  always_comb begin
    w_state_d = r_state;
    w_xition  = X_NONE;
    if (w_accept) begin
      if (r_state == INIT) begin
        w_state_d = TRACK;
      end else begin
        w_xition = decode(w_prev, w_next);
      end
    end
    w_count = ((w_xition == X_UP) || (w_xition == X_DOWN)) && !load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= INIT;
      r_position <= '0;
      r_dir      <= 1'b0;
      r_step     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_step  <= w_count;
      if (load) begin
        r_position <= load_value;
      end else if (w_xition == X_UP) begin
        r_position <= r_position + WIDTH'(1);
      end else if (w_xition == X_DOWN) begin
        r_position <= r_position - WIDTH'(1);
      end
      if (w_count) begin
        r_dir <= (w_xition == X_UP);
      end
      // A new illegal transition outranks a simultaneous clear.
      if (w_xition == X_ILLEGAL) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign position = r_position;
  assign dir      = r_dir;
  assign step     = r_step;
  assign err      = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder with default parameters.
module tb_quad_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_in;
  logic        b_in;
  logic        load;
  logic [15:0] load_value;
  logic        err_clr;
  logic [15:0] position;
  logic        dir;
  logic        step;
  logic        err;

  int checks  = 0;
  int errors  = 0;
  int n_steps = 0;
  int base;

  quad_decoder #(
    .WIDTH      (16),
    .SYNC_STAGES(2),
    .FILTER_LEN (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_in      (a_in),
    .b_in      (b_in),
    .load      (load),
    .load_value(load_value),
    .err_clr   (err_clr),
    .position  (position),
    .dir       (dir),
    .step      (step),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Counts clock cycles with step high, so a stretched pulse is also caught.
  always @(posedge clk) begin
    if (step === 1'b1) n_steps <= n_steps + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // From a negedge: pass n rising edges, then stop on the following negedge.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Drive a new {A,B} at a negedge; acceptance is expected on the 5th rising edge (E0+4).
  task automatic xition(input logic a, input logic b, input logic [15:0] pos0,
                        input logic [15:0] pos1, input logic dir1, input logic step1);
    a_in = a;
    b_in = b;
    edges(4);
    check("pre_accept_pos", {16'h0, position}, {16'h0, pos0});
    check("pre_accept_step", {31'h0, step}, 32'h0);
    edges(1);
    check("accept_pos", {16'h0, position}, {16'h0, pos1});
    check("accept_step", {31'h0, step}, {31'h0, step1});
    check("accept_dir", {31'h0, dir}, {31'h0, dir1});
    edges(1);
    check("step_one_cycle", {31'h0, step}, 32'h0);
    edges(2);
  endtask

  initial begin
    rst        = 1'b1;
    a_in       = 1'b1;
    b_in       = 1'b1;
    load       = 1'b0;
    load_value = 16'h0;
    err_clr    = 1'b0;
    edges(2);
    check("reset_pos", {16'h0, position}, 32'h0);
    check("reset_dir", {31'h0, dir}, 32'h0);
    check("reset_step", {31'h0, step}, 32'h0);
    check("reset_err", {31'h0, err}, 32'h0);

    // INIT adopts 11 silently.
    rst  = 1'b0;
    base = n_steps;
    edges(10);
    check("init11_pos", {16'h0, position}, 32'h0);
    check("init11_err", {31'h0, err}, 32'h0);
    check("init11_nostep", n_steps - base, 0);

    // Restart from 00 and count up four times.
    rst  = 1'b1;
    a_in = 1'b0;
    b_in = 1'b0;
    edges(1);
    rst = 1'b0;
    edges(10);
    base = n_steps;
    xition(1'b1, 1'b0, 16'd0, 16'd1, 1'b1, 1'b1);
    xition(1'b1, 1'b1, 16'd1, 16'd2, 1'b1, 1'b1);
    xition(1'b0, 1'b1, 16'd2, 16'd3, 1'b1, 1'b1);
    xition(1'b0, 1'b0, 16'd3, 16'd4, 1'b1, 1'b1);
    check("up_step_cycles", n_steps - base, 4);

    // Load 1, then count down through zero.
    load_value = 16'h0001;
    load       = 1'b1;
    edges(1);
    load = 1'b0;
    check("load1_pos", {16'h0, position}, 32'h1);
    xition(1'b0, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b1);
    xition(1'b1, 1'b1, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
    xition(1'b1, 1'b0, 16'hFFFF, 16'hFFFE, 1'b0, 1'b1);

    // Two-cycle glitch on A from 10 must be rejected.
    base = n_steps;
    a_in = 1'b0;
    edges(2);
    a_in = 1'b1;
    edges(10);
    check("glitch_pos", {16'h0, position}, 32'hFFFE);
    check("glitch_nostep", n_steps - base, 0);
    check("glitch_err", {31'h0, err}, 32'h0);

    // 10 -> 00 legally, then 00 -> 11 is illegal.
    xition(1'b0, 1'b0, 16'hFFFE, 16'hFFFD, 1'b0, 1'b1);
    xition(1'b1, 1'b1, 16'hFFFD, 16'hFFFD, 1'b0, 1'b0);
    check("illegal_err", {31'h0, err}, 32'h1);
    edges(3);
    check("err_sticky", {31'h0, err}, 32'h1);
    err_clr = 1'b1;
    edges(1);
    err_clr = 1'b0;
    check("err_cleared", {31'h0, err}, 32'h0);

    // Load coincides with acceptance of 11 -> 01 (up): load wins, no step, dir held.
    a_in = 1'b0;
    b_in = 1'b1;
    edges(4);
    check("collide_pre_pos", {16'h0, position}, 32'hFFFD);
    load_value = 16'h1234;
    load       = 1'b1;
    edges(1);
    load = 1'b0;
    check("collide_pos", {16'h0, position}, 32'h1234);
    check("collide_step", {31'h0, step}, 32'h0);
    check("collide_dir", {31'h0, dir}, 32'h0);
    edges(3);
    xition(1'b0, 1'b0, 16'h1234, 16'h1235, 1'b1, 1'b1);

    // Set err, load 7, then async reset mid-cycle.
    xition(1'b1, 1'b1, 16'h1235, 16'h1235, 1'b1, 1'b0);
    load_value = 16'h0007;
    load       = 1'b1;
    edges(1);
    load = 1'b0;
    check("pre_rst_pos", {16'h0, position}, 32'h7);
    check("pre_rst_err", {31'h0, err}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pos", {16'h0, position}, 32'h0);
    check("async_rst_err", {31'h0, err}, 32'h0);
    check("async_rst_dir", {31'h0, dir}, 32'h0);
    check("async_rst_step", {31'h0, step}, 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    base = n_steps;
    edges(10);
    check("reinit_nostep", n_steps - base, 0);
    check("reinit_pos", {16'h0, position}, 32'h0);
    xition(1'b0, 1'b1, 16'h0000, 16'h0001, 1'b1, 1'b1);
    check("reinit_err", {31'h0, err}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
